// File: rtl/cpu_pkg.sv
// Shared CPU constants and small types used across the front-end pipeline.
package cpu_pkg;

  localparam int unsigned      XLEN             = 32;
  localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned      INSTR_BYTES      = 4;
  // Canonical ADDI x0,x0,0; decode substitutes it while fetch has nothing valid.
  localparam logic [XLEN-1:0]  NOP_INSTR        = 32'h0000_0013;

  typedef enum logic {
    MODE_RUN   = 1'b0,
    MODE_FLUSH = 1'b1
  } fetch_mode_e;

endpackage

// File: rtl/sync_fifo.sv
// Small power-of-two synchronous FIFO with occupancy count and synchronous clear.
module sync_fifo #(
  parameter int unsigned  WIDTH = 32,
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_pop_c;

  assign do_pop_c = pop_i && (count_q != '0);
  assign rdata_o  = mem_q[rd_ptr_q];
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (push_i && !do_pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_i && do_pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited imem reads, buffers
// returned words for decode and discards in-flight data after a redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned  N        = XLEN,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT),
  parameter int unsigned  DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [N-1:0] imem_rsp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_pc,
  output logic [N-1:0] out_pc_plus4,
  output logic [N-1:0] out_instr
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [N-1:0]     fetch_pc_q;
  logic [N-1:0]     fetch_pc_d;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] drop_d;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] fifo_count;
  logic [N-1:0]     inflight_pc;
  logic [2*N-1:0]   head;
  logic             credit_ok_c;
  logic             accept_c;
  logic             push_c;
  logic             pop_c;
  fetch_mode_e      mode_c;

  // Non-zero drop count means responses still belong to a squashed path.
  assign mode_c = (drop_q != '0) ? MODE_FLUSH : MODE_RUN;

  // Buffered plus in-flight words never exceed DEPTH, so responses need no backpressure.
  assign credit_ok_c     = (SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(DEPTH);
  assign imem_req_valid  = !reset && !redirect_valid && credit_ok_c;
  assign imem_req_addr   = fetch_pc_q;
  assign accept_c        = imem_req_valid && imem_req_ready;
  assign push_c          = imem_rsp_valid && (mode_c == MODE_RUN) && !redirect_valid;
  assign pop_c           = out_valid && out_ready;
  assign outstanding_nxt = outstanding + CNT_W'(accept_c) - CNT_W'(imem_rsp_valid);

  assign out_valid    = (fifo_count != '0);
  assign out_pc       = head[2*N-1:N];
  assign out_instr    = head[N-1:0];
  assign out_pc_plus4 = out_pc + N'(INSTR_BYTES);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~N'(INSTR_BYTES - 1);
      drop_d     = outstanding_nxt;
    end else begin
      if (accept_c) begin
        fetch_pc_d = fetch_pc_q + N'(INSTR_BYTES);
      end
      if (imem_rsp_valid && (mode_c == MODE_FLUSH)) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  // Tracks addresses of accepted requests; its occupancy is the outstanding count.
  sync_fifo #(
    .WIDTH (N),
    .DEPTH (DEPTH)
  ) u_inflight_q (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (1'b0),
    .push_i  (accept_c),
    .wdata_i (fetch_pc_q),
    .pop_i   (imem_rsp_valid),
    .rdata_o (inflight_pc),
    .count_o (outstanding)
  );

  sync_fifo #(
    .WIDTH (2 * N),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (redirect_valid),
    .push_i  (push_c),
    .wdata_i ({inflight_pc, imem_rsp_data}),
    .pop_i   (pop_c),
    .rdata_o (head),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-modelled instruction memory and
// an expected-delivery queue that is flushed on every redirect.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  fetch_unit #(
    .N        (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .out_instr      (out_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] expq[$];
  logic [31:0] model_pc;
  int          model_fifo;
  int          model_drop;
  int          n_cmp;
  int          n_err;
  int          cycle_no;
  int          n_acc;
  int          deliv_cnt;
  int          lat;
  bit          rand_lat;
  bit          saw_wrap;
  logic [31:0] first_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle_no);
    end
  endtask

  // One clock: drive memory response, check outputs, advance the reference model.
  task automatic cycle();
    logic        rsp;
    logic [31:0] rsp_addr;
    logic        exp_rv;
    logic        pop;
    logic [31:0] e;
    int          d;
    rsp      = 1'b0;
    rsp_addr = 32'h0;
    if (memq.size() > 0 && memq[0].due <= cycle_no) begin
      rsp      = 1'b1;
      rsp_addr = memq[0].addr;
      void'(memq.pop_front());
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(rsp_addr) : 32'h0;
    #2;
    exp_rv = !redirect_valid && ((memq.size() + int'(rsp) + model_fifo) < int'(DEPTH));
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("out_valid", 32'(out_valid), 32'(model_fifo > 0));
    pop = (model_fifo > 0) && out_ready;
    if (pop) begin
      if (expq.size() == 0) begin
        chk("deliv_pending", 32'(expq.size()), 32'd1);
      end else begin
        e = expq.pop_front();
        chk("out_pc", out_pc, e);
        chk("out_instr", out_instr, mem_word(e));
        chk("out_pc_plus4", out_pc_plus4, e + 32'd4);
        if (deliv_cnt == 0) first_pc = out_pc;
        if (e == 32'hFFFF_FFFC) saw_wrap = 1'b1;
        deliv_cnt++;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, model_pc);
      d = cycle_no + (rand_lat ? int'($urandom_range(1, 3)) : lat);
      expq.push_back(model_pc);
      memq.push_back('{addr: model_pc, due: d});
      model_pc = model_pc + 32'd4;
      n_acc++;
    end
    if (rsp) begin
      if (model_drop > 0) model_drop--;
      else if (!redirect_valid) model_fifo++;
    end
    if (pop) model_fifo--;
    if (redirect_valid) begin
      model_fifo = 0;
      expq.delete();
      model_drop = memq.size();
      model_pc   = redirect_pc & ~32'h3;
      deliv_cnt  = 0;
    end
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    memq.delete();
    expq.delete();
    model_pc   = 32'h0;
    model_fifo = 0;
    model_drop = 0;
    deliv_cnt  = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int waited;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    out_ready      = 1'b0;
    n_cmp = 0; n_err = 0; cycle_no = 0; n_acc = 0;
    lat = 1; rand_lat = 1'b0; saw_wrap = 1'b0; first_pc = 32'h0;
    do_reset();

    // Free-running stream, then reset mid-stream restarts at address 0
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    repeat (20) cycle();
    do_reset();
    repeat (6) cycle();

    // Decode stalled: only DEPTH requests may be issued
    do_reset();
    out_ready = 1'b0;
    n_acc     = 0;
    repeat (8) cycle();
    chk("stall_accepts", 32'(n_acc), 32'd2);
    out_ready = 1'b1;
    repeat (10) cycle();

    // Redirect with two outstanding requests at 3-cycle latency
    do_reset();
    lat = 3;
    cycle();
    cycle();
    chk("outstanding_pre_redir", 32'(memq.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    cycle();
    redirect_valid = 1'b0;
    repeat (12) cycle();
    chk("first_pc_redir_103", first_pc, 32'h0000_0100);

    // Redirect coinciding with a response and an output handshake
    lat    = 1;
    waited = 0;
    while (!(model_fifo > 0 && memq.size() > 0 && memq[0].due <= cycle_no) && waited < 50) begin
      cycle();
      waited++;
    end
    chk("same_cycle_event_found", 32'(waited < 50), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    cycle();
    redirect_valid = 1'b0;
    repeat (10) cycle();
    chk("first_pc_redir_200", first_pc, 32'h0000_0200);

    // Address wrap at the top of the address space
    saw_wrap       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0;
    repeat (12) cycle();
    chk("first_pc_wrap", first_pc, 32'hFFFF_FFF8);
    chk("wrap_delivered", 32'(saw_wrap), 32'd1);

    // Back-to-back redirects, then random traffic
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1000;
    cycle();
    redirect_pc    = 32'h0000_2002;
    cycle();
    redirect_valid = 1'b0;
    repeat (10) cycle();
    chk("first_pc_b2b", first_pc, 32'h0000_2000);

    rand_lat = 1'b1;
    for (int i = 0; i < 500; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    repeat (20) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
